// File: rtl/vram_loader_if.sv
// Stream and video-bus bundle for vram_loader: receive stream in, transmit
// stream out, and the strobe/address/data bus toward the video block.
interface vram_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        sel_ram;
  logic        sel_ctl;
  logic        we;
  logic [12:0] addr;
  logic [7:0]  din;
  logic [7:0]  ram_dout;
  logic [7:0]  ctl_dout;
  logic        busy;

  // The loader drives the video bus and consumes the receive stream
  modport master (
    input  rx_data, rx_valid, tx_ready, ram_dout, ctl_dout,
    output rx_ready, tx_data, tx_valid, sel_ram, sel_ctl, we, addr, din, busy
  );

  // Environment side: UART receiver/transmitter and the video block
  modport slave (
    output rx_data, rx_valid, tx_ready, ram_dout, ctl_dout,
    input  rx_ready, tx_data, tx_valid, sel_ram, sel_ctl, we, addr, din, busy
  );
endinterface

// File: rtl/vram_loader.sv
// Byte-stream command parser feeding VRAM and control registers of the video
// block. Opcodes: W block write, F fill, C control write, R VRAM read, S
// control read. All strobes are registered single-cycle pulses.
module vram_loader #(
  parameter int TIMEOUT = 1200000
) (
  input logic          clk,
  input logic          reset,
  vram_loader_if.master bus
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_F = 8'h46;
  localparam logic [7:0] OP_C = 8'h43;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_S = 8'h53;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARG   = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_RSTB  = 3'd4;
  localparam logic [2:0] S_RCAP  = 3'd5;
  localparam logic [2:0] S_TX    = 3'd6;

  logic [2:0]    state;
  logic [7:0]    op;
  logic [2:0]    idx;
  logic [7:0]    arg [0:3];
  logic [12:0]   ptr;
  logic [13:0]   cnt;
  logic [7:0]    fill_val;
  logic          rd_ctl;
  logic [TW-1:0] tcnt;

  logic          rx_ready_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          sel_ram_q;
  logic          sel_ctl_q;
  logic          we_q;
  logic [12:0]   addr_q;
  logic [7:0]    din_q;

  logic          accept;
  logic          last_arg;
  logic [12:0]   hdr_addr;
  logic [12:0]   rd_addr;
  logic [12:0]   fill_cnt;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == OP_W) || (b == OP_F) || (b == OP_C) || (b == OP_R) || (b == OP_S);
  endfunction

  function automatic logic [2:0] arg_count(input logic [7:0] o);
    case (o)
      OP_W:    return 3'd3;
      OP_F:    return 3'd5;
      OP_C:    return 3'd2;
      OP_R:    return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  assign accept   = bus.rx_valid & rx_ready_q;
  assign last_arg = (idx == (arg_count(op) - 3'd1));
  assign hdr_addr = {arg[0][4:0], arg[1]};
  assign rd_addr  = {arg[0][4:0], bus.rx_data};
  assign fill_cnt = {arg[2][4:0], arg[3]};

  assign bus.rx_ready = rx_ready_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.sel_ram  = sel_ram_q;
  assign bus.sel_ctl  = sel_ctl_q;
  assign bus.we       = we_q;
  assign bus.addr     = addr_q;
  assign bus.din      = din_q;
  assign bus.busy     = (state != S_IDLE);

  // Command FSM: parses the byte stream and issues registered access strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op         <= '0;
      idx        <= '0;
      for (int i = 0; i < 4; i++) arg[i] <= '0;
      ptr        <= '0;
      cnt        <= '0;
      fill_val   <= '0;
      rd_ctl     <= 1'b0;
      tcnt       <= '0;
      rx_ready_q <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      sel_ram_q  <= 1'b0;
      sel_ctl_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      sel_ram_q <= 1'b0;
      sel_ctl_q <= 1'b0;
      we_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          rx_ready_q <= 1'b1;
          tcnt       <= '0;
          if (accept && is_cmd(bus.rx_data)) begin
            op    <= bus.rx_data;
            idx   <= '0;
            state <= S_ARG;
          end
        end

        S_ARG: begin
          if (accept) begin
            tcnt <= '0;
            if (!last_arg) begin
              arg[idx[1:0]] <= bus.rx_data;
              idx           <= idx + 3'd1;
            end else begin
              case (op)
                OP_W: begin
                  ptr   <= hdr_addr;
                  cnt   <= (bus.rx_data == 8'd0) ? 14'd256 : {6'd0, bus.rx_data};
                  state <= S_WDATA;
                end
                OP_F: begin
                  sel_ram_q  <= 1'b1;
                  we_q       <= 1'b1;
                  addr_q     <= hdr_addr;
                  din_q      <= bus.rx_data;
                  fill_val   <= bus.rx_data;
                  ptr        <= hdr_addr + 13'd1;
                  cnt        <= (fill_cnt == 13'd0) ? 14'd8191 : ({1'b0, fill_cnt} - 14'd1);
                  rx_ready_q <= 1'b0;
                  state      <= S_FILL;
                end
                OP_C: begin
                  sel_ctl_q <= 1'b1;
                  we_q      <= 1'b1;
                  addr_q    <= {5'd0, arg[0]};
                  din_q     <= bus.rx_data;
                  state     <= S_IDLE;
                end
                OP_R: begin
                  sel_ram_q  <= 1'b1;
                  addr_q     <= rd_addr;
                  rd_ctl     <= 1'b0;
                  rx_ready_q <= 1'b0;
                  state      <= S_RSTB;
                end
                OP_S: begin
                  sel_ctl_q  <= 1'b1;
                  addr_q     <= {5'd0, bus.rx_data};
                  rd_ctl     <= 1'b1;
                  rx_ready_q <= 1'b0;
                  state      <= S_RSTB;
                end
                default: state <= S_IDLE;
              endcase
            end
          end else if (tcnt == TLAST) begin
            tcnt  <= '0;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_WDATA: begin
          if (accept) begin
            tcnt      <= '0;
            sel_ram_q <= 1'b1;
            we_q      <= 1'b1;
            addr_q    <= ptr;
            din_q     <= bus.rx_data;
            ptr       <= ptr + 13'd1;
            if (cnt == 14'd1) begin
              rx_ready_q <= 1'b1;
              state      <= S_IDLE;
            end else begin
              cnt        <= cnt - 14'd1;
              rx_ready_q <= 1'b0;
            end
          end else begin
            rx_ready_q <= 1'b1;
            if (tcnt == TLAST) begin
              tcnt  <= '0;
              state <= S_IDLE;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end

        S_FILL: begin
          if (cnt == 14'd0) begin
            rx_ready_q <= 1'b1;
            state      <= S_IDLE;
          end else begin
            sel_ram_q <= 1'b1;
            we_q      <= 1'b1;
            addr_q    <= ptr;
            din_q     <= fill_val;
            ptr       <= ptr + 13'd1;
            cnt       <= cnt - 14'd1;
          end
        end

        S_RSTB: state <= S_RCAP;

        S_RCAP: begin
          tx_data_q  <= rd_ctl ? bus.ctl_dout : bus.ram_dout;
          tx_valid_q <= 1'b1;
          state      <= S_TX;
        end

        S_TX: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_loader.sv
// Scoreboard bench for vram_loader: a packet-level reference model queues the
// expected writes and readback bytes, a negedge monitor checks them as the DUT
// presents them, and a small video-block model answers read strobes.
module tb_vram_loader;

  localparam int TIMEOUT = 16;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic        ctl;
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   total_wr = 0;
  int   acc_cyc = 0;

  wr_t        exp_wr [$];
  logic [7:0] exp_tx [$];
  bit   [7:0] ref_mem [0:8191];
  bit   [7:0] ref_ctl [0:255];
  bit   [7:0] vid_mem [0:8191];
  bit   [7:0] ctl_mem [0:255];

  vram_loader_if bus();

  vram_loader #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Video block model: writes land in memory, reads answer the next cycle
  always @(posedge clk) begin
    if (bus.sel_ram && bus.we) vid_mem[bus.addr] <= bus.din;
    if (bus.sel_ctl && bus.we) ctl_mem[bus.addr[7:0]] <= bus.din;
    if (bus.sel_ram && !bus.we) bus.ram_dout <= vid_mem[bus.addr];
    if (bus.sel_ctl && !bus.we) bus.ctl_dout <= ctl_mem[bus.addr[7:0]];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bound_expired(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired (got none, expected event)", name);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT writes or transmits
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    wr_t        e;
    logic [7:0] t;
    logic [12:0] a;
    if (bus.sel_ram && bus.sel_ctl) check_output("sel_exclusive", 32'd1, 32'd0);
    if ((bus.sel_ram || bus.sel_ctl) && bus.we) begin
      total_wr++;
      if (exp_wr.size() == 0) begin
        check_output("unexpected_write", {9'd0, bus.sel_ctl, bus.addr, bus.din}, 32'd0);
      end else begin
        e = exp_wr.pop_front();
        a = bus.sel_ctl ? {5'd0, bus.addr[7:0]} : bus.addr;
        check_output("write", {9'd0, bus.sel_ctl, a, bus.din}, {9'd0, e});
      end
    end
    if (prev_hold && !reset)
      check_output("tx_hold", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, prev_data});
    if (bus.tx_valid && bus.tx_ready) begin
      if (exp_tx.size() == 0) begin
        check_output("unexpected_tx", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
      end else begin
        t = exp_tx.pop_front();
        check_output("tx_data", {24'd0, bus.tx_data}, {24'd0, t});
      end
    end
    prev_hold = bus.tx_valid && !bus.tx_ready && !reset;
    prev_data = bus.tx_data;
  end

  task automatic push_wr(input logic ctl, input logic [12:0] a, input logic [7:0] d);
    wr_t e;
    e.ctl  = ctl;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
    if (ctl) ref_ctl[a[7:0]] = d;
    else ref_mem[a] = d;
  endtask

  // Reference model: what a whole packet must do, in plain arithmetic
  task automatic model_packet(input bq_t p);
    logic [7:0]  b1, b2, b3, b4, b5;
    logic [12:0] a;
    int          n;
    b1 = (p.size() > 1) ? p[1] : 8'd0;
    b2 = (p.size() > 2) ? p[2] : 8'd0;
    b3 = (p.size() > 3) ? p[3] : 8'd0;
    b4 = (p.size() > 4) ? p[4] : 8'd0;
    b5 = (p.size() > 5) ? p[5] : 8'd0;
    a  = {b1[4:0], b2};
    case (p[0])
      8'h57: begin
        n = (b3 == 8'd0) ? 256 : int'(b3);
        for (int i = 0; i < n; i++) begin
          push_wr(1'b0, a, p[4 + i]);
          a = a + 13'd1;
        end
      end
      8'h46: begin
        n = int'({b3[4:0], b4});
        if (n == 0) n = 8192;
        for (int i = 0; i < n; i++) begin
          push_wr(1'b0, a, b5);
          a = a + 13'd1;
        end
      end
      8'h43: push_wr(1'b1, {5'd0, b1}, b2);
      8'h52: exp_tx.push_back(ref_mem[a]);
      8'h53: exp_tx.push_back(ref_ctl[b1]);
      default: ;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic done;
    done = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    bus.rx_valid = 1'b0;
    if (!done) bound_expired("rx_accept");
  endtask

  task automatic send_bytes(input bq_t p, input int gap_max);
    for (int i = 0; i < p.size(); i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) @(posedge clk);
        #1;
      end
      send_byte(p[i]);
    end
  endtask

  task automatic apply_stimulus(input bq_t p, input int gap_max);
    model_packet(p);
    send_bytes(p, gap_max);
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
    end
    if (!done) bound_expired(name);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outputs();
    return {bus.rx_ready, bus.tx_valid, bus.sel_ram, bus.sel_ctl, bus.we, bus.busy,
            bus.addr, bus.din | bus.tx_data};
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bq_t        p;
    int         bad;
    int         n0;
    int         r;
    logic [7:0] b;

    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;

    // Reset values, then rx_ready rising right after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_outputs", all_outputs(), 32'd0);
    check_output("reset_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check_output("reset_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("rx_ready_before_edge", {31'd0, bus.rx_ready}, 32'd0);
    @(negedge clk);
    check_output("rx_ready_after_reset", {31'd0, bus.rx_ready}, 32'd1);
    @(posedge clk);
    #1;

    // W across the top of VRAM
    p = '{8'h57, 8'h1F, 8'hFE, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    model_packet(p);
    send_byte(8'h57); send_byte(8'h1F); send_byte(8'hFE); send_byte(8'h04);
    send_byte(8'h11);
    @(negedge clk);
    check_output("w_first_strobe_rx_ready", {30'd0, bus.sel_ram & bus.we, bus.rx_ready}, 32'd2);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk);
    check_output("w_last_strobe", {31'd0, bus.sel_ram & bus.we}, 32'd1);
    @(posedge clk);
    #1;

    // W with n=0 means 256 bytes
    p = '{8'hE0, 8'hBC, 8'h00};
    p.push_front(8'h57);
    for (int i = 0; i < 256; i++) p.push_back(8'($urandom));
    n0 = total_wr;
    apply_stimulus(p, 0);
    @(negedge clk);
    @(negedge clk);
    check_output("w256_count", total_wr - n0, 32'd256);
    check_output("w256_idle", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;

    // Full 8192-byte fill wrapping from 0x0010 to 0x000F
    p = '{8'h46, 8'h00, 8'h10, 8'h00, 8'h00, 8'h5A};
    apply_stimulus(p, 0);
    bad = 0;
    for (int i = 0; i < 8192; i++) begin
      @(negedge clk);
      if (!(bus.sel_ram && bus.we) || bus.rx_ready) bad++;
    end
    check_output("fill_full_cycles", bad, 32'd0);
    @(negedge clk);
    check_output("fill_full_end", {29'd0, bus.busy, bus.rx_ready, bus.sel_ram}, 32'd2);
    @(posedge clk);
    #1;

    // R with 20 cycles of backpressure
    apply_stimulus('{8'h57, 8'h01, 8'h23, 8'h01, 8'h3C}, 0);
    bus.tx_ready = 1'b0;
    apply_stimulus('{8'h52, 8'h01, 8'h23}, 0);
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i < 3) check_output("r_tx_valid_early", {31'd0, bus.tx_valid}, 32'd0);
      if (i == 3) check_output("r_tx_valid_rise", {23'd0, bus.tx_valid, bus.tx_data}, 32'h13C);
    end
    @(posedge clk);
    #1 bus.tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("r_idle_after_accept", {30'd0, bus.busy, bus.tx_valid}, 32'd0);
    @(posedge clk);
    #1;

    // C then S reading back the same register
    apply_stimulus('{8'h43, 8'h07, 8'h9E}, 0);
    @(negedge clk);
    check_output("c_strobe", {30'd0, bus.sel_ctl & bus.we, bus.sel_ram}, 32'd2);
    @(posedge clk);
    #1;
    apply_stimulus('{8'h53, 8'h07}, 0);
    wait_idle("s_idle");

    // Mid-packet timeout, then junk opcode and a control write
    send_byte(8'h57);
    send_byte(8'h00);
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      @(negedge clk);
      if (i == TIMEOUT) check_output("timeout_still_busy", {31'd0, bus.busy}, 32'd1);
      if (i == TIMEOUT + 1) check_output("timeout_idle", {31'd0, bus.busy}, 32'd0);
    end
    @(posedge clk);
    #1;
    apply_stimulus('{8'hFF}, 0);
    apply_stimulus('{8'h43, 8'h01, 8'h02}, 0);
    wait_idle("junk_idle");

    // Randomized packets against the reference model
    for (int k = 0; k < 40; k++) begin
      p = {};
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        p.push_back(8'h57); p.push_back(8'($urandom)); p.push_back(8'($urandom));
        b = 8'($urandom_range(1, 8));
        p.push_back(b);
        for (int i = 0; i < int'(b); i++) p.push_back(8'($urandom));
        apply_stimulus(p, 2);
      end else if (r <= 4) begin
        p.push_back(8'h46); p.push_back(8'($urandom)); p.push_back(8'($urandom));
        p.push_back({3'($urandom), 5'd0}); p.push_back(8'($urandom_range(1, 20)));
        p.push_back(8'($urandom));
        apply_stimulus(p, 2);
      end else if (r == 5) begin
        p.push_back(8'h43); p.push_back(8'($urandom)); p.push_back(8'($urandom));
        apply_stimulus(p, 2);
      end else if (r <= 8) begin
        if (r == 8) begin
          p.push_back(8'h53); p.push_back(8'($urandom));
        end else begin
          p.push_back(8'h52); p.push_back(8'($urandom)); p.push_back(8'($urandom));
        end
        bus.tx_ready = 1'b0;
        apply_stimulus(p, 2);
        repeat ($urandom_range(3, 8)) @(posedge clk);
        #1 bus.tx_ready = 1'b1;
        wait_idle("rand_read_idle");
      end else begin
        b = 8'h57;
        for (int i = 0; i < 50 && (b == 8'h57 || b == 8'h46 || b == 8'h43 ||
                                   b == 8'h52 || b == 8'h53); i++) b = 8'($urandom);
        if (b == 8'h57 || b == 8'h46 || b == 8'h43 || b == 8'h52 || b == 8'h53) b = 8'h00;
        p.push_back(b);
        apply_stimulus(p, 2);
      end
    end
    wait_idle("rand_final_idle");

    // Reset in the middle of a 4096-byte fill
    for (int i = 0; i < 100; i++) push_wr(1'b0, 13'(i), 8'hAA);
    n0 = total_wr;
    send_bytes('{8'h46, 8'h00, 8'h00, 8'h10, 8'h00, 8'hAA}, 0);
    bad = 0;
    for (int i = 0; i < 200 && bad < 100; i++) begin
      @(negedge clk);
      if (bus.sel_ram && bus.we) bad++;
    end
    #2 reset = 1'b1;
    #1;
    check_output("reset_mid_fill_outputs", all_outputs(), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_output("reset_hold_outputs", all_outputs(), 32'd0);
    end
    check_output("reset_mid_fill_writes", total_wr - n0, 32'd100);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("after_reset_no_writes", total_wr - n0, 32'd100);

    check_output("exp_wr_drained", exp_wr.size(), 32'd0);
    check_output("exp_tx_drained", exp_tx.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
